// File: rtl/mux_rr_arbiter_if.sv
// Requester/consumer bundle for the round-robin output-channel arbiter.
// The arbiter takes the master side; producers and the consumer sit on the slave side.
interface mux_rr_arbiter_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SW = $clog2(N);

    logic [N-1:0]   req;
    logic [N*W-1:0] din;
    logic [N-1:0]   ready;
    logic [W-1:0]   dout;
    logic           dvalid;
    logic           dready;
    logic [SW-1:0]  sel;
    logic [N-1:0]   gnt;
    logic           busy;

    modport master (
        input  req, din, dready,
        output ready, dout, dvalid, sel, gnt, busy
    );

    modport slave (
        output req, din, dready,
        input  ready, dout, dvalid, sel, gnt, busy
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin burst arbiter steering an N:1 tree of 2:1 muxes onto one valid/ready channel.
//   state   | meaning
//   S_IDLE  | no grant; gnt=0, waiting for any req
//   S_GRANT | sel owns the channel for up to MAX_BURST accepted beats
module mux_rr_arbiter #(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_rr_arbiter_if.master bus
);
    localparam int SW = $clog2(N);
    localparam int NP = 1 << SW;
    localparam int CW = 8;

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t        state;
    logic [SW-1:0] sel;
    logic [SW-1:0] ptr;
    logic [N-1:0]  gnt;
    logic [CW-1:0] cnt;

    logic          busy;
    logic          xfer;
    logic          release_a;
    logic          release_b;
    logic          do_release;
    logic [SW-1:0] ptr_next;
    logic [SW-1:0] base;
    logic [N-1:0]  cand;
    logic          win_found;
    logic [SW-1:0] win_idx;
    logic [W-1:0]  tree [NP];

    assign busy       = (state == S_GRANT);
    assign bus.busy   = busy;
    assign bus.sel    = sel;
    assign bus.gnt    = gnt;
    assign bus.dvalid = bus.req[sel] & busy;
    assign bus.ready  = gnt & {N{bus.dready}};
    assign bus.dout   = busy ? tree[0] : '0;

    assign ptr_next = (sel == SW'(N - 1)) ? '0 : sel + SW'(1);

    always_comb begin
        int idx;
        idx        = 0;
        xfer       = bus.dvalid & bus.dready;
        release_a  = xfer && (cnt == CW'(MAX_BURST - 1));
        release_b  = busy && !bus.req[sel];
        do_release = busy && (release_a || release_b);
        // After a release the scan restarts just past the holder, which puts the holder last.
        base       = busy ? ptr_next : ptr;
        cand       = bus.req;
        if (release_b) cand[sel] = 1'b0;
        win_found  = 1'b0;
        win_idx    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(base) + k;
            if (idx >= N) idx = idx - N;
            if (cand[idx]) begin
                win_found = 1'b1;
                win_idx   = SW'(idx);
            end
        end
    end

    // Binary tree of 2:1 muxes; stage s consumes select bit s.
    always_comb begin
        for (int i = 0; i < NP; i++) tree[i] = '0;
        for (int i = 0; i < N; i++) tree[i] = bus.din[i*W +: W];
        for (int s = 0; s < SW; s++) begin
            for (int j = 0; j < (NP >> (s + 1)); j++) begin
                tree[j] = sel[s] ? tree[2*j+1] : tree[2*j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            sel   <= '0;
            ptr   <= '0;
            gnt   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        state <= S_GRANT;
                        sel   <= win_idx;
                        gnt   <= N'(1) << win_idx;
                        cnt   <= '0;
                    end
                end
                S_GRANT: begin
                    if (do_release) begin
                        ptr <= ptr_next;
                        cnt <= '0;
                        if (win_found) begin
                            sel <= win_idx;
                            gnt <= N'(1) << win_idx;
                        end else begin
                            state <= S_IDLE;
                            gnt   <= '0;
                        end
                    end else if (xfer) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
